// File: rtl/plab5_mcore_mem_resp_sched.sv
// Round-robin scheduler that serialises full memory responses from several banks
// onto one narrow network port as a header flit plus an optional data flit.
module plab5_mcore_mem_resp_sched #(
  parameter  int p_num_reqs     = 4,
  parameter  int p_opaque_nbits = 8,
  parameter  int p_data_nbits   = 32,
  localparam int l              = $clog2(p_data_nbits / 8),
  localparam int c              = 3 + p_opaque_nbits + l,
  localparam int m              = c + p_data_nbits,
  localparam int s              = $clog2(p_num_reqs)
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [p_num_reqs-1:0]   in_val,
  output logic [p_num_reqs-1:0]   in_rdy,
  input  logic [p_num_reqs*m-1:0] in_msg,
  output logic                    out_val,
  input  logic                    out_rdy,
  output logic [p_data_nbits-1:0] out_msg,
  output logic                    out_last,
  output logic [s-1:0]            out_src
);

  typedef enum logic [1:0] {IDLE, HDR, DATA} state_t;

  state_t                  state_reg;
  logic [s-1:0]            ptr_reg;
  // The header travels in out_msg, so only the data half of the message is buffered.
  logic [p_data_nbits-1:0] buf_reg;

  logic                    any_val;
  logic [s-1:0]            grant;
  logic [s-1:0]            ptr_next;
  logic [m-1:0]            gmsg;
  logic [2:0]              gtype;
  logic                    ghdr_only;

  // Walk downward so the last hit wins: that is the first set bit at or after ptr.
  always_comb begin
    int idx;
    any_val = 1'b0;
    grant   = '0;
    idx     = 0;
    for (int k = p_num_reqs - 1; k >= 0; k--) begin
      idx = int'(ptr_reg) + k;
      if (idx >= p_num_reqs) idx = idx - p_num_reqs;
      if (in_val[idx[s-1:0]]) begin
        any_val = 1'b1;
        grant   = idx[s-1:0];
      end
    end
  end

  always_comb begin
    gmsg = '0;
    for (int i = 0; i < p_num_reqs; i++) begin
      if (grant == s'(i)) gmsg = in_msg[i*m +: m];
    end
  end

  assign gtype     = gmsg[m-1 -: 3];
  assign ghdr_only = (gtype == 3'd1) || (gtype == 3'd2);
  assign ptr_next  = (grant == s'(p_num_reqs - 1)) ? '0 : grant + 1'b1;

  // Gated by reset_n so no source sees an accept while reset is held.
  always_comb begin
    in_rdy = '0;
    if (reset_n && (state_reg == IDLE) && any_val) in_rdy[grant] = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= IDLE;
      ptr_reg   <= '0;
      buf_reg   <= '0;
      out_val   <= 1'b0;
      out_msg   <= '0;
      out_last  <= 1'b0;
      out_src   <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (any_val) begin
            state_reg <= HDR;
            ptr_reg   <= ptr_next;
            buf_reg   <= gmsg[p_data_nbits-1:0];
            out_val   <= 1'b1;
            out_msg   <= p_data_nbits'(gmsg[m-1 -: c]);
            out_last  <= ghdr_only;
            out_src   <= grant;
          end
        end
        HDR: begin
          if (out_rdy) begin
            if (out_last) begin
              state_reg <= IDLE;
              out_val   <= 1'b0;
              out_msg   <= '0;
              out_last  <= 1'b0;
              out_src   <= '0;
            end else begin
              state_reg <= DATA;
              out_msg   <= buf_reg;
              out_last  <= 1'b1;
            end
          end
        end
        DATA: begin
          if (out_rdy) begin
            state_reg <= IDLE;
            out_val   <= 1'b0;
            out_msg   <= '0;
            out_last  <= 1'b0;
            out_src   <= '0;
          end
        end
        default: begin
          state_reg <= IDLE;
          out_val   <= 1'b0;
          out_msg   <= '0;
          out_last  <= 1'b0;
          out_src   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_plab5_mcore_mem_resp_sched.sv
// Directed bench for plab5_mcore_mem_resp_sched: a cycle table plus hand sequences
// for round-robin fairness and asynchronous reset in the middle of a data flit.
module tb_plab5_mcore_mem_resp_sched;
  localparam int N = 4;
  localparam int M = 45;

  logic           clk = 1'b0;
  logic           reset_n = 1'b0;
  logic [N-1:0]   in_val = '0;
  logic [N-1:0]   in_rdy;
  logic [N*M-1:0] in_msg = '0;
  logic           out_val;
  logic           out_rdy = 1'b1;
  logic [31:0]    out_msg;
  logic           out_last;
  logic [1:0]     out_src;

  plab5_mcore_mem_resp_sched #(.p_num_reqs(N), .p_opaque_nbits(8), .p_data_nbits(32)) dut (
    .clk(clk), .reset_n(reset_n), .in_val(in_val), .in_rdy(in_rdy), .in_msg(in_msg),
    .out_val(out_val), .out_rdy(out_rdy), .out_msg(out_msg), .out_last(out_last), .out_src(out_src)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [M-1:0] mk(input logic [2:0] t, input logic [7:0] o, input logic [31:0] d);
    return {t, o, 2'b00, d};
  endfunction

  typedef struct {
    logic [3:0]  val;
    logic [2:0]  typ;
    logic [7:0]  opq;
    logic [31:0] data;
    logic        rdy;
    logic [3:0]  e_rdy;
    logic        e_val;
    logic [31:0] e_msg;
    logic        e_last;
    logic [1:0]  e_src;
  } vec_t;

  vec_t vt[20];

  function automatic vec_t mkv(input logic [3:0] val, input logic [2:0] typ, input logic [7:0] opq,
                               input logic [31:0] data, input logic rdy, input logic [3:0] e_rdy,
                               input logic e_val, input logic [31:0] e_msg, input logic e_last,
                               input logic [1:0] e_src);
    vec_t v;
    v.val = val; v.typ = typ; v.opq = opq; v.data = data; v.rdy = rdy;
    v.e_rdy = e_rdy; v.e_val = e_val; v.e_msg = e_msg; v.e_last = e_last; v.e_src = e_src;
    return v;
  endfunction

  initial begin
    // read from source 2 (ptr 0 -> 3)
    vt[0]  = mkv(4'b0100, 3'd0, 8'h5A, 32'hDEADBEEF, 1'b1, 4'b0100, 1'b0, 32'h0, 1'b0, 2'd0);
    vt[1]  = mkv(4'b0000, 3'd0, 8'h5A, 32'hDEADBEEF, 1'b1, 4'b0000, 1'b1, 32'h00000168, 1'b0, 2'd2);
    vt[2]  = mkv(4'b0000, 3'd0, 8'h5A, 32'hDEADBEEF, 1'b1, 4'b0000, 1'b1, 32'hDEADBEEF, 1'b1, 2'd2);
    vt[3]  = mkv(4'b0000, 3'd0, 8'h5A, 32'hDEADBEEF, 1'b1, 4'b0000, 1'b0, 32'h0, 1'b0, 2'd0);
    // write from source 1 (ptr 3 -> 2), single flit, idle two cycles after accept
    vt[4]  = mkv(4'b0010, 3'd1, 8'h11, 32'h0, 1'b1, 4'b0010, 1'b0, 32'h0, 1'b0, 2'd0);
    vt[5]  = mkv(4'b0000, 3'd1, 8'h11, 32'h0, 1'b1, 4'b0000, 1'b1, 32'h00000444, 1'b1, 2'd1);
    vt[6]  = mkv(4'b0000, 3'd1, 8'h11, 32'h0, 1'b1, 4'b0000, 1'b0, 32'h0, 1'b0, 2'd0);
    // unknown type 7 from source 0 (ptr 2 -> 1), header plus data
    vt[7]  = mkv(4'b0001, 3'd7, 8'h00, 32'h12345678, 1'b1, 4'b0001, 1'b0, 32'h0, 1'b0, 2'd0);
    vt[8]  = mkv(4'b0000, 3'd7, 8'h00, 32'h12345678, 1'b1, 4'b0000, 1'b1, 32'h00001C00, 1'b0, 2'd0);
    vt[9]  = mkv(4'b0000, 3'd7, 8'h00, 32'h12345678, 1'b1, 4'b0000, 1'b1, 32'h12345678, 1'b1, 2'd0);
    vt[10] = mkv(4'b0000, 3'd7, 8'h00, 32'h12345678, 1'b1, 4'b0000, 1'b0, 32'h0, 1'b0, 2'd0);
    // read from source 3 (ptr 1 -> 0) with the header stalled for 5 cycles
    vt[11] = mkv(4'b1000, 3'd0, 8'hFF, 32'hCAFEF00D, 1'b0, 4'b1000, 1'b0, 32'h0, 1'b0, 2'd0);
    for (int i = 12; i < 17; i++)
      vt[i] = mkv(4'b1111, 3'd0, 8'hFF, 32'hCAFEF00D, 1'b0, 4'b0000, 1'b1, 32'h000003FC, 1'b0, 2'd3);
    vt[17] = mkv(4'b0000, 3'd0, 8'hFF, 32'hCAFEF00D, 1'b1, 4'b0000, 1'b1, 32'h000003FC, 1'b0, 2'd3);
    vt[18] = mkv(4'b0000, 3'd0, 8'hFF, 32'hCAFEF00D, 1'b1, 4'b0000, 1'b1, 32'hCAFEF00D, 1'b1, 2'd3);
    vt[19] = mkv(4'b0000, 3'd0, 8'hFF, 32'hCAFEF00D, 1'b1, 4'b0000, 1'b0, 32'h0, 1'b0, 2'd0);

    // reset state; requests present during reset must not be accepted
    in_val = 4'b1111;
    in_msg = {N{mk(3'd1, 8'h00, 32'h0)}};
    repeat (2) @(negedge clk);
    #1;
    chk("reset_out_val", 32'(out_val), 32'd0);
    chk("reset_in_rdy", 32'(in_rdy), 32'd0);
    chk("reset_ptr", 32'(dut.ptr_reg), 32'd0);
    in_val  = '0;
    reset_n = 1'b1;

    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      in_val  = vt[i].val;
      in_msg  = {N{mk(vt[i].typ, vt[i].opq, vt[i].data)}};
      out_rdy = vt[i].rdy;
      #1;
      $display("[TB] row %0d: in_rdy=%b out_val=%b out_msg=%h out_last=%b out_src=%0d",
               i, in_rdy, out_val, out_msg, out_last, out_src);
      chk($sformatf("row%0d_in_rdy", i), 32'(in_rdy), 32'(vt[i].e_rdy));
      chk($sformatf("row%0d_out_val", i), 32'(out_val), 32'(vt[i].e_val));
      if (vt[i].e_val) begin
        chk($sformatf("row%0d_out_msg", i), out_msg, vt[i].e_msg);
        chk($sformatf("row%0d_out_last", i), 32'(out_last), 32'(vt[i].e_last));
      end
      chk($sformatf("row%0d_out_src", i), 32'(out_src), 32'(vt[i].e_src));
    end
    chk("table_end_ptr", 32'(dut.ptr_reg), 32'd0);

    // round-robin: all sources hold write responses from reset
    @(negedge clk);
    in_val  = '0;
    out_rdy = 1'b1;
    reset_n = 1'b0;
    #2 reset_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      in_val = 4'b1111;
      in_msg = {N{mk(3'd1, 8'h00, 32'h0)}};
      #1;
      $display("[TB] rr grant %0d: in_rdy=%b", k, in_rdy);
      chk($sformatf("rr%0d_in_rdy", k), 32'(in_rdy), 32'(4'b0001 << (k % 4)));
      if (k == 0) begin
        @(posedge clk);
        #1 chk("rr_ptr_after_first", 32'(dut.ptr_reg), 32'd1);
      end
      @(negedge clk);
      #1;
      chk($sformatf("rr%0d_out_src", k), 32'(out_src), 32'(k % 4));
      chk($sformatf("rr%0d_out_last", k), 32'(out_last), 32'd1);
    end

    // reset in the middle of a stalled data flit (ptr is 1, so source 1 wins)
    @(negedge clk);
    in_val  = 4'b0010;
    in_msg  = {N{mk(3'd0, 8'h22, 32'hA5A5A5A5)}};
    out_rdy = 1'b0;
    #1 chk("rst_accept_in_rdy", 32'(in_rdy), 32'(4'b0010));
    @(negedge clk);
    in_val  = '0;
    out_rdy = 1'b1;
    #1 chk("rst_hdr_msg", out_msg, 32'h00000088);
    @(negedge clk);
    out_rdy = 1'b0;
    in_val  = 4'b1000;
    #1;
    chk("rst_data_val", 32'(out_val), 32'd1);
    chk("rst_data_msg", out_msg, 32'hA5A5A5A5);
    @(posedge clk);
    #1 reset_n = 1'b0;
    #1;
    $display("[TB] reset mid-DATA: out_val=%b in_rdy=%b", out_val, in_rdy);
    chk("rst_out_val_drop", 32'(out_val), 32'd0);
    chk("rst_in_rdy_zero", 32'(in_rdy), 32'd0);
    #1 reset_n = 1'b1;
    #1;
    chk("rst_ptr", 32'(dut.ptr_reg), 32'd0);
    chk("rst_src3_in_rdy", 32'(in_rdy), 32'(4'b1000));
    @(posedge clk);
    #1;
    in_val = '0;
    chk("rst_src3_out_val", 32'(out_val), 32'd1);
    chk("rst_src3_out_src", 32'(out_src), 32'd3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/plab5_mcore_mem_resp_sched.md
# plab5_mcore_mem_resp_sched

Round-robin scheduler that shares one narrow memory-response network port among `p_num_reqs` memory-bank response sources. It accepts full memory response messages (type, opaque, len, data) and emits them as one or two `p_data_nbits`-wide flits. The first flit is the packed control header; the second flit is the data, and it is sent only for responses that carry data. The block sits between the banked memory response outputs and the response network injection port of the multicore.

## Interface
- `p_num_reqs`, 4, number of response sources (2..8)
- `p_opaque_nbits`, 8, opaque field width `o`
- `p_data_nbits`, 32, data width `d`; must satisfy `d >= c`
- `c` (derived), control header width = 3 + `o` + `l`, where `l` = clog2(`d`/8); 13 with the defaults
- `s` (derived), clog2(`p_num_reqs`)

Ports:
- `clk`  in  1  sole clock; all state updates on the rising edge
- `reset_n`  in  1  asynchronous, active-low reset
- `in_val`  in  `p_num_reqs`  per-source response valid
- `in_rdy`  out  `p_num_reqs`  per-source accept; at most one bit high in any cycle
- `in_msg`  in  `p_num_reqs`*(`c`+`d`)  flattened messages
  - source i occupies bits [i*(c+d) +: c+d]
  - layout within a message: type[c+d-1 -: 3], opaque, len, data[d-1:0]
- `out_val`  out  1  flit valid
- `out_rdy`  in  1  network accept
- `out_msg`  out  `d`  flit payload
- `out_last`  out  1  marks the final flit of the current message
- `out_src`  out  `s`  index of the source that owns the current flit
- All ports carry security label L.

## Operation
- State machine with three states: IDLE, HDR, DATA.
- One-entry message buffer `buf`, holding c+d bits.
- Round-robin pointer `ptr`, `s` bits wide.
- **IDLE**
  - `out_val` = 0.
  - If any `in_val` is set, grant the first set bit searching from `ptr` upward with wrap-around.
  - Assert `in_rdy[g]` combinationally in that same cycle, where `g` is the granted source.
  - At the clock edge: `buf` ← `in_msg[g]`, `src` ← g, `ptr` ← (g+1) mod `p_num_reqs`, then go to HDR.
  - If no `in_val` is set, stay in IDLE.
- **HDR**
  - `out_val` = 1.
  - `out_msg` = control header {type, opaque, len}, zero-extended to `d` bits; bit layout is type[c-1:c-3], opaque[c-4:l], len[l-1:0].
  - `out_last` = 1 when type is WRITE (3'd1) or WRITE_INIT (3'd2); otherwise 0 (READ 3'd0, AMO 3'd3–3'd5).
  - When `out_rdy` = 1: go to IDLE if `out_last` = 1, else go to DATA.
- **DATA**
  - `out_val` = 1, `out_msg` = buffered data, `out_last` = 1.
  - When `out_rdy` = 1, go to IDLE.
- `out_src` = `src` whenever `out_val` = 1; it is 0 otherwise.
- `in_rdy` is all-zero in HDR and DATA, so no source is accepted while a message is in flight.
- Unknown type codes (3'd6, 3'd7) are sent as header plus data.
- `out_msg`, `out_last` and `out_src` hold steady for as long as `out_val` = 1 and `out_rdy` = 0. A stalled flit is never altered.
- `in_val` may drop without a handshake; only an asserted `in_rdy` constitutes acceptance.

## Timing
- Reset, asserted asynchronously at any time including mid-message:
  - State → IDLE, `ptr` → 0, `src` → 0, `buf` → 0; the in-flight message is dropped.
  - `out_val` and `in_rdy` go to 0 immediately, without waiting for a clock edge.
- After `reset_n` deasserts, the first grant can happen in the first clock cycle.
- Latency from accept to header flit is 1 cycle: the accept cycle is in IDLE, and the header is valid in the next cycle.
- Minimum occupancy with `out_rdy` held at 1:
  - header-only messages: 2 cycles per message;
  - data messages: 3 cycles per message.
- Simultaneous requests resolve by pointer order only. A source that keeps `in_val` asserted is served within `p_num_reqs` messages.
- The pointer advances only on a grant. Idle cycles and stalls leave it unchanged.

## Test plan
- **Read response, single source:** after reset, source 2 sends type 0, opaque 0x5A, len 0, data 0xDEADBEEF with `out_rdy` = 1.
  - Required: `in_rdy` = 4'b0100 in the accept cycle.
  - Next cycle: `out_msg` = 0x00000168, `out_last` = 0, `out_src` = 2.
  - Following cycle: `out_msg` = 0xDEADBEEF, `out_last` = 1.
- **Write response:** source 1 sends type 1, opaque 0x11, len 0.
  - Required: a single flit with `out_msg` = 0x00000444 and `out_last` = 1.
  - The block is back in IDLE 2 cycles after the accept.
- **Round-robin:** all 4 sources hold write responses continuously from reset.
  - Required: grant order 0, 1, 2, 3, 0.
  - `ptr` = 1 after the first grant.
- **Backpressure:** hold `out_rdy` = 0 for 5 cycles during HDR of a read response.
  - Required: `out_msg`, `out_last` and `out_src` are stable throughout, and all `in_rdy` bits are 0.
  - The data flit follows exactly 1 cycle after `out_rdy` rises.
- **Reset mid-DATA:** pulse `reset_n` low between clock edges while a DATA flit is stalled.
  - Required: `out_val` drops at once.
  - After release, `ptr` = 0, and a pending request from source 3 alone is granted first.
- **Unknown type:** send type 3'd7.
  - Required: two flits are emitted, the second with `out_last` = 1.
